// File: rtl/draw_point_arbiter_if.sv
// rtl/draw_point_arbiter_if.sv - request/response signal bundle for draw_point_arbiter
interface draw_point_arbiter_if;
  logic        clear_req;
  logic [11:0] clear_rgb;
  logic        req0_valid;
  logic [8:0]  req0_pos_x;
  logic [8:0]  req0_pos_y;
  logic [11:0] req0_rgb;
  logic        req0_ready;
  logic        req1_valid;
  logic [8:0]  req1_pos_x;
  logic [8:0]  req1_pos_y;
  logic [11:0] req1_rgb;
  logic        req1_ready;
  logic        update;
  logic [8:0]  pos_x;
  logic [8:0]  pos_y;
  logic [11:0] rgb;
  logic        clear_busy;
  logic        clear_done;
  logic [15:0] drop_count;

  // Requester/controller side: drives requests, observes handshakes and the write port
  modport master (
    output clear_req, clear_rgb,
    output req0_valid, req0_pos_x, req0_pos_y, req0_rgb,
    output req1_valid, req1_pos_x, req1_pos_y, req1_rgb,
    input  req0_ready, req1_ready,
    input  update, pos_x, pos_y, rgb, clear_busy, clear_done, drop_count
  );

  // Arbiter side
  modport slave (
    input  clear_req, clear_rgb,
    input  req0_valid, req0_pos_x, req0_pos_y, req0_rgb,
    input  req1_valid, req1_pos_x, req1_pos_y, req1_rgb,
    output req0_ready, req1_ready,
    output update, pos_x, pos_y, rgb, clear_busy, clear_done, drop_count
  );
endinterface

// File: rtl/draw_point_arbiter.sv
// rtl/draw_point_arbiter.sv - two-requester round-robin DrawPoint arbiter with frame clear
module draw_point_arbiter #(
  parameter int HRES = 320,
  parameter int VRES = 240
) (
  input  logic        piul1Clock,
  input  logic        piul1Reset_n,
  input  logic        piul1ClearReq,
  input  logic [11:0] piul12ClearRgb,
  input  logic        piul1Req0Valid,
  input  logic [8:0]  piul9Req0PosX,
  input  logic [8:0]  piul9Req0PosY,
  input  logic [11:0] piul12Req0Rgb,
  output logic        poul1Req0Ready,
  input  logic        piul1Req1Valid,
  input  logic [8:0]  piul9Req1PosX,
  input  logic [8:0]  piul9Req1PosY,
  input  logic [11:0] piul12Req1Rgb,
  output logic        poul1Req1Ready,
  output logic        poul1Update,
  output logic [8:0]  poul9PosX,
  output logic [8:0]  poul9PosY,
  output logic [11:0] poul12Rgb12Data,
  output logic        poul1ClearBusy,
  output logic        poul1ClearDone,
  output logic [15:0] poul16DropCount
);

  localparam logic [8:0] X_LAST = 9'(HRES - 1);
  localparam logic [8:0] Y_LAST = 9'(VRES - 1);
  localparam logic [9:0] X_LIM  = 10'(HRES);
  localparam logic [9:0] Y_LIM  = 10'(VRES);

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [8:0]  x_q, x_d, y_q, y_d;
  logic [11:0] clr_rgb_q, clr_rgb_d;
  logic        last_q, last_d;
  logic        update_q, update_d;
  logic [8:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [11:0] rgb_q, rgb_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] drop_q, drop_d;

  logic        gnt0, gnt1, accept_ok, ready0, ready1;
  logic [8:0]  sel_x, sel_y;
  logic [11:0] sel_rgb;

  // Round-robin grant and combinational readies; last_q==1 means requester 1 won last
  always_comb begin
    gnt0      = piul1Req0Valid && (!piul1Req1Valid || last_q);
    gnt1      = piul1Req1Valid && (!piul1Req0Valid || !last_q);
    accept_ok = piul1Reset_n && (state_q == ST_IDLE) && !piul1ClearReq;
    ready0    = accept_ok && gnt0;
    ready1    = accept_ok && gnt1;
    sel_x     = ready1 ? piul9Req1PosX : piul9Req0PosX;
    sel_y     = ready1 ? piul9Req1PosY : piul9Req0PosY;
    sel_rgb   = ready1 ? piul12Req1Rgb : piul12Req0Rgb;
  end

  assign poul1Req0Ready = ready0;
  assign poul1Req1Ready = ready1;

  // Next-state: point transfers in IDLE, raster clear sweep, one-cycle DONE
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    clr_rgb_d = clr_rgb_q;
    last_d    = last_q;
    update_d  = 1'b0;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    rgb_d     = rgb_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    drop_d    = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (piul1ClearReq) begin
          // First clear pixel goes out together with entering CLEAR
          state_d   = ST_CLEAR;
          clr_rgb_d = piul12ClearRgb;
          x_d       = '0;
          y_d       = '0;
          update_d  = 1'b1;
          pos_x_d   = '0;
          pos_y_d   = '0;
          rgb_d     = piul12ClearRgb;
          busy_d    = 1'b1;
        end else if (ready0 || ready1) begin
          last_d = ready1;
          if (({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM)) begin
            update_d = 1'b1;
            pos_x_d  = sel_x;
            pos_y_d  = sel_y;
            rgb_d    = sel_rgb;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
      end
      ST_CLEAR: begin
        // x_q/y_q track the pixel currently on the write port
        if (x_q == X_LAST && y_q == Y_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 9'd1;
          end else begin
            x_d = x_q + 9'd1;
          end
          update_d = 1'b1;
          busy_d   = 1'b1;
          pos_x_d  = x_d;
          pos_y_d  = y_d;
          rgb_d    = clr_rgb_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset leaves requester 1 as last winner
  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      clr_rgb_q <= '0;
      last_q    <= 1'b1;
      update_q  <= 1'b0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      rgb_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      clr_rgb_q <= clr_rgb_d;
      last_q    <= last_d;
      update_q  <= update_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      rgb_q     <= rgb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  assign poul1Update     = update_q;
  assign poul9PosX       = pos_x_q;
  assign poul9PosY       = pos_y_q;
  assign poul12Rgb12Data = rgb_q;
  assign poul1ClearBusy  = busy_q;
  assign poul1ClearDone  = done_q;
  assign poul16DropCount = drop_q;

endmodule
